// File: rtl/pattern_pulse_generator.sv
// Rotating pattern register that plays a loaded pattern out serially in bursts of full rotations.
// Optional macro PATTERN_PULSE_GEN_DIR_EN enables right rotation via DIR; without it rotation is always left.
module pattern_pulse_generator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] INP,
    input  logic             LOAD,
    input  logic             START,
    input  logic             STOP,
    input  logic [CNT_W-1:0] NUM_ROT,
    input  logic             DIR,
    output logic             OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_SHIFT = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [SHW-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0] rot_q, rot_d;

    logic             rotRight;
    logic             wrap;
    logic             lastRot;
    logic             startOk;
    logic [WIDTH-1:0] rotated;

`ifdef PATTERN_PULSE_GEN_DIR_EN
    assign rotRight = DIR;
`else
    logic unused_dir;
    assign unused_dir = DIR;
    assign rotRight   = 1'b0;
`endif

    // A latched count of zero never reaches lastRot, which gives continuous mode.
    assign wrap    = (shift_q == LAST_SHIFT);
    assign lastRot = wrap && (rot_q == CNT_W'(1));
    assign startOk = START && !STOP;
    assign rotated = rotRight ? {pattern_q[0], pattern_q[WIDTH-1:1]}
                              : {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            shift_q   <= '0;
            rot_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            shift_q   <= shift_d;
            rot_q     <= rot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (LOAD) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (startOk) state_d = ST_RUN;
                ST_RUN: begin
                    if (STOP)         state_d = ST_IDLE;
                    else if (lastRot) state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pattern_d = pattern_q;
        shift_d   = shift_q;
        rot_d     = rot_q;
        if (LOAD) begin
            pattern_d = INP;
            shift_d   = '0;
            rot_d     = '0;
        end else if (state_q == ST_IDLE && startOk) begin
            shift_d = '0;
            rot_d   = NUM_ROT;
        end else if (state_q == ST_RUN && !STOP) begin
            pattern_d = rotated;
            shift_d   = wrap ? '0 : shift_q + SHW'(1);
            if (wrap && rot_q != '0) begin
                rot_d = rot_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        BUSY = (state_q == ST_RUN);
        DONE = (state_q == ST_DONE);
        OUT  = rotRight ? pattern_q[0] : pattern_q[WIDTH-1];
    end

endmodule

// File: tb/tb_pattern_pulse_generator.sv
// Directed bench for pattern_pulse_generator (WIDTH=8, CNT_W=4); expectations follow PATTERN_PULSE_GEN_DIR_EN.
module tb_pattern_pulse_generator;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [WIDTH-1:0] INP;
    logic             LOAD;
    logic             START;
    logic             STOP;
    logic [CNT_W-1:0] NUM_ROT;
    logic             DIR;
    logic             OUT;
    logic             BUSY;
    logic             DONE;

    int totalChecks = 0;
    int badChecks   = 0;

    pattern_pulse_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .INP(INP), .LOAD(LOAD), .START(START), .STOP(STOP),
        .NUM_ROT(NUM_ROT), .DIR(DIR), .OUT(OUT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change on the falling edge, outputs are sampled there too.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] value);
        LOAD = 1'b1;
        INP  = value;
        tick();
        LOAD = 1'b0;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] rots);
        NUM_ROT = rots;
        START   = 1'b1;
        tick();
        START   = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        totalChecks++;
        if (OUT !== 1'b0) begin badChecks++; $display("FAIL reset_out: got %b want 0", OUT); end
        totalChecks++;
        if (BUSY !== 1'b0) begin badChecks++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        totalChecks++;
        if (DONE !== 1'b0) begin badChecks++; $display("FAIL reset_done: got %b want 0", DONE); end
        totalChecks++;
        if (dut.pattern_q !== 8'h00) begin badChecks++; $display("FAIL reset_q: got %h want 00", dut.pattern_q); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_single_burst();
        logic expOut [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int busyCount;
        DIR = 1'b0;
        do_load(8'hA0);
        totalChecks++;
        if (OUT !== 1'b1) begin badChecks++; $display("FAIL burst_pre_out: got %b want 1", OUT); end
        do_start(4'd1);
        busyCount = BUSY ? 1 : 0;
        totalChecks++;
        if (OUT !== 1'b1) begin badChecks++; $display("FAIL burst_start_noshift: got %b want 1", OUT); end
        for (int n = 0; n < 8; n++) begin
            tick();
            if (BUSY) busyCount++;
            totalChecks++;
            if (OUT !== expOut[n]) begin
                badChecks++; $display("FAIL burst_out shift %0d: got %b want %b", n + 1, OUT, expOut[n]);
            end
            totalChecks++;
            if (DONE !== (n == 7)) begin
                badChecks++; $display("FAIL burst_done shift %0d: got %b want %b", n + 1, DONE, (n == 7));
            end
        end
        totalChecks++;
        if (busyCount != 8) begin badChecks++; $display("FAIL burst_busy_cycles: got %0d want 8", busyCount); end
        tick();
        totalChecks++;
        if (DONE !== 1'b0) begin badChecks++; $display("FAIL burst_done_width: got %b want 0", DONE); end
        totalChecks++;
        if (BUSY !== 1'b0) begin badChecks++; $display("FAIL burst_idle_busy: got %b want 0", BUSY); end
        totalChecks++;
        if (dut.pattern_q !== 8'hA0) begin badChecks++; $display("FAIL burst_final_q: got %h want a0", dut.pattern_q); end
    endtask

    task automatic test_continuous_stop();
        int doneCount = 0;
        do_load(8'hA0);
        do_start(4'd0);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (DONE) doneCount++;
        end
        totalChecks++;
        if (BUSY !== 1'b1) begin badChecks++; $display("FAIL cont_still_busy: got %b want 1", BUSY); end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        if (DONE) doneCount++;
        totalChecks++;
        if (dut.pattern_q !== 8'h0A) begin badChecks++; $display("FAIL cont_stop_q: got %h want 0a", dut.pattern_q); end
        totalChecks++;
        if (BUSY !== 1'b0) begin badChecks++; $display("FAIL cont_stop_busy: got %b want 0", BUSY); end
        tick();
        if (DONE) doneCount++;
        totalChecks++;
        if (doneCount != 0) begin badChecks++; $display("FAIL cont_no_done: got %0d pulses want 0", doneCount); end
        totalChecks++;
        if (dut.pattern_q !== 8'h0A) begin badChecks++; $display("FAIL cont_idle_hold: got %h want 0a", dut.pattern_q); end
    endtask

    task automatic test_load_priority();
        do_load(8'hA0);
        do_start(4'd1);
        tick();
        tick();
        tick();
        do_load(8'h3C);
        totalChecks++;
        if (dut.pattern_q !== 8'h3C) begin badChecks++; $display("FAIL load_run_q: got %h want 3c", dut.pattern_q); end
        totalChecks++;
        if (BUSY !== 1'b0) begin badChecks++; $display("FAIL load_run_busy: got %b want 0", BUSY); end
        totalChecks++;
        if (OUT !== 1'b0) begin badChecks++; $display("FAIL load_run_out: got %b want 0", OUT); end
        tick();
        totalChecks++;
        if (DONE !== 1'b0) begin badChecks++; $display("FAIL load_run_done: got %b want 0", DONE); end
        LOAD  = 1'b1;
        START = 1'b1;
        INP   = 8'h55;
        tick();
        LOAD  = 1'b0;
        START = 1'b0;
        totalChecks++;
        if (dut.pattern_q !== 8'h55) begin badChecks++; $display("FAIL load_start_q: got %h want 55", dut.pattern_q); end
        tick();
        totalChecks++;
        if (BUSY !== 1'b0) begin badChecks++; $display("FAIL load_start_idle: got %b want 0", BUSY); end
    endtask

    task automatic test_start_stop_idle();
        NUM_ROT = 4'd1;
        START   = 1'b1;
        STOP    = 1'b1;
        tick();
        START   = 1'b0;
        STOP    = 1'b0;
        totalChecks++;
        if (BUSY !== 1'b0) begin badChecks++; $display("FAIL start_stop_busy: got %b want 0", BUSY); end
        tick();
        totalChecks++;
        if (dut.pattern_q !== 8'h55) begin badChecks++; $display("FAIL start_stop_q: got %h want 55", dut.pattern_q); end
    endtask

    task automatic test_num_rot_latch();
        int busyCount;
        logic found = 1'b0;
        do_load(8'hA0);
        do_start(4'd2);
        NUM_ROT   = 4'd1;
        busyCount = BUSY ? 1 : 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (DONE) found = 1'b1;
            else if (BUSY) busyCount++;
        end
        totalChecks++;
        if (found !== 1'b1) begin badChecks++; $display("FAIL rot2_done_timeout: got %b want 1", found); end
        totalChecks++;
        if (busyCount != 16) begin badChecks++; $display("FAIL rot2_busy_cycles: got %0d want 16", busyCount); end
        tick();
        totalChecks++;
        if (dut.pattern_q !== 8'hA0) begin badChecks++; $display("FAIL rot2_final_q: got %h want a0", dut.pattern_q); end
    endtask

    task automatic test_direction();
        logic expBit;
        do_load(8'h01);
        DIR = 1'b1;
`ifdef PATTERN_PULSE_GEN_DIR_EN
        expBit = 1'b1;
`else
        expBit = 1'b0;
`endif
        totalChecks++;
        if (OUT !== expBit) begin badChecks++; $display("FAIL dir_pre_out: got %b want %b", OUT, expBit); end
        do_start(4'd1);
        for (int n = 1; n <= 8; n++) begin
            tick();
`ifdef PATTERN_PULSE_GEN_DIR_EN
            expBit = (n == 8);
`else
            expBit = (n == 7);
`endif
            totalChecks++;
            if (OUT !== expBit) begin
                badChecks++; $display("FAIL dir_out shift %0d: got %b want %b", n, OUT, expBit);
            end
        end
        totalChecks++;
        if (DONE !== 1'b1) begin badChecks++; $display("FAIL dir_done: got %b want 1", DONE); end
        tick();
        totalChecks++;
        if (dut.pattern_q !== 8'h01) begin badChecks++; $display("FAIL dir_final_q: got %h want 01", dut.pattern_q); end
        DIR = 1'b0;
    endtask

    task automatic test_async_reset();
        do_load(8'hA0);
        do_start(4'd0);
        tick();
        tick();
        totalChecks++;
        if (OUT !== 1'b1) begin badChecks++; $display("FAIL areset_pre_out: got %b want 1", OUT); end
        #2 RESET = 1'b1;
        #1;
        totalChecks++;
        if (OUT !== 1'b0) begin badChecks++; $display("FAIL areset_out: got %b want 0", OUT); end
        totalChecks++;
        if (BUSY !== 1'b0) begin badChecks++; $display("FAIL areset_busy: got %b want 0", BUSY); end
        totalChecks++;
        if (DONE !== 1'b0) begin badChecks++; $display("FAIL areset_done: got %b want 0", DONE); end
        totalChecks++;
        if (dut.pattern_q !== 8'h00) begin badChecks++; $display("FAIL areset_q: got %h want 00", dut.pattern_q); end
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        totalChecks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            badChecks++; $display("FAIL areset_no_resume: got busy=%b done=%b want 0 0", BUSY, DONE);
        end
        do_start(4'd1);
        for (int n = 1; n <= 8; n++) begin
            tick();
            totalChecks++;
            if (OUT !== 1'b0) begin badChecks++; $display("FAIL areset_zero_out shift %0d: got %b want 0", n, OUT); end
        end
        totalChecks++;
        if (DONE !== 1'b1) begin badChecks++; $display("FAIL areset_zero_done: got %b want 1", DONE); end
        tick();
    endtask

    initial begin
        RESET   = 1'b1;
        INP     = '0;
        LOAD    = 1'b0;
        START   = 1'b0;
        STOP    = 1'b0;
        NUM_ROT = '0;
        DIR     = 1'b0;
        $display("[TB] starting pattern_pulse_generator bench");
        test_reset();
        test_single_burst();
        test_continuous_stop();
        test_load_priority();
        test_start_stop_idle();
        test_num_rot_latch();
        test_direction();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
